// File: rtl/dev_hex_display.sv
// dev_hex_display: two-digit multiplexed 7-segment driver (PmodSSD style).
// Shows an 8-bit value as two hex digits. The digit select alternates at
// REFRESH_HZ, and the display blanks while en is low.
// Optional build macro DEV_HEX_LEADING_ZERO_BLANK_EN blanks a zero high digit.
// All outputs are registered, so no combinational path runs from inputs to pins.
module dev_hex_display #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int REFRESH_HZ = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] hex_val,
  output logic [7:0] hex_pins
);

  localparam int DIV = CLK_FREQ / REFRESH_HZ;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("dev_hex_display: CLK_FREQ/REFRESH_HZ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic          sel;
  logic [7:0]    val_q;
  logic          blank_q;
  logic [3:0]    digit;
  logic [6:0]    seg;
  logic          seg_off;

  // Segment pattern lookup, bit6..0 = gfedcba, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Refresh counter: wraps at DIV-1 and flips the digit select in that cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge values of the others.
    if (rst) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Input stage: capture the value while enabled, and register the blank request.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= 8'h00;
      blank_q <= 1'b1;
    end else begin
      if (en) val_q <= hex_val;
      blank_q <= ~en;
    end
  end

  // Digit mux and segment decode for the digit that sel is about to light.
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    digit   = 4'h0;
    seg_off = blank_q;
    digit   = sel ? val_q[7:4] : val_q[3:0];
`ifdef DEV_HEX_LEADING_ZERO_BLANK_EN
    if (sel && (val_q[7:4] == 4'h0)) seg_off = 1'b1;
`endif
    seg = seg_off ? 7'h00 : hex_to_seg(digit);
  end

  // Output register: select and matching segments change together, so no ghosting.
  always_ff @(posedge clk) begin
    if (rst) hex_pins <= 8'h00;
    else     hex_pins <= {sel, seg};
  end

endmodule

// File: tb/tb_dev_hex_display.sv
// Testbench for dev_hex_display with DIV = 100/10 = 10.
// The stimulus process pushes the expected pin value for each clock edge into
// a scoreboard queue. A separate monitor pops and compares it after that edge.
module tb_dev_hex_display;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] hex_val;
  logic [7:0] hex_pins;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       checks   = 0;
  int       failures = 0;
  string    phase    = "reset";

  // Reference model state: non-reset edges since the last reset edge,
  // the captured value, and the blank flag.
  int         nr      = 0;
  logic [7:0] m_val   = 8'h00;
  logic       m_blank = 1'b1;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  dev_hex_display #(.CLK_FREQ(100), .REFRESH_HZ(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .hex_val (hex_val),
    .hex_pins(hex_pins)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs on the falling edge and queue the expected pins after that edge.
  task automatic step(input logic r, input logic e, input logic [7:0] v);
    sb_item_t it;
    logic     sel_prev;
    logic     off;
    logic [3:0] dg;
    @(negedge clk);
    rst     = r;
    en      = e;
    hex_val = v;
    if (r) begin
      it.exp = 8'h00;
    end else begin
      sel_prev = ((nr / 10) % 2) == 1;
      dg  = sel_prev ? m_val[7:4] : m_val[3:0];
      off = m_blank;
`ifdef DEV_HEX_LEADING_ZERO_BLANK_EN
      if (sel_prev && m_val[7:4] == 4'h0) off = 1'b1;
`endif
      it.exp = {sel_prev, off ? 7'h00 : seg_tab[dg]};
    end
    it.tag = phase;
    sb_q.push_back(it);
    if (r) begin
      nr      = 0;
      m_val   = 8'h00;
      m_blank = 1'b1;
    end else begin
      nr++;
      if (e) m_val = v;
      m_blank = ~e;
    end
  endtask

  // Monitor: compare the DUT pins with the oldest expected value, just after each edge.
  initial begin
    sb_item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check(it.tag, hex_pins, it.exp);
      end
    end
  end

  // Watchdog: the stimulus is finite, but the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    hex_val = 8'h00;

    // Reset, then idle blanked: select toggles, segments stay dark.
    phase = "reset";
    repeat (3) step(1'b1, 1'b0, 8'h00);
    phase = "blank_idle";
    repeat (35) step(1'b0, 1'b0, 8'h00);

    // Basic display of 0x3A.
    phase = "show_3A";
    repeat (40) step(1'b0, 1'b1, 8'h3A);

    // Sweep all 16 nibble values on both digits. Changes land mid-digit.
    phase = "sweep";
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = {i[3:0], i[3:0]};
      repeat (40) step(1'b0, 1'b1, v);
    end

    // Blanking, then recovery with the value unchanged.
    phase = "show_5C";
    repeat (20) step(1'b0, 1'b1, 8'h5C);
    phase = "blank_5C";
    repeat (25) step(1'b0, 1'b0, 8'h5C);
    phase = "unblank_5C";
    repeat (20) step(1'b0, 1'b1, 8'h5C);

    // en toggling every cycle, with a changing value.
    phase = "en_toggle";
    for (int i = 0; i < 12; i++) step(1'b0, i[0], 8'h80 + 8'(i));

    // Reset mid-refresh when the counter sits at 6.
    phase = "pre_rst_E7";
    step(1'b0, 1'b1, 8'hE7);
    while ((nr % 10) != 6) step(1'b0, 1'b1, 8'hE7);
    phase = "mid_rst";
    step(1'b1, 1'b1, 8'hE7);
    phase = "post_rst_E7";
    repeat (35) step(1'b0, 1'b1, 8'hE7);

    // Leading-zero case; the expected high digit depends on the build macro.
    phase = "show_05";
    repeat (40) step(1'b0, 1'b1, 8'h05);
    phase = "show_0A";
    repeat (25) step(1'b0, 1'b1, 8'h0A);

    // Let the monitor drain the queue, then confirm nothing is left unchecked.
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dev_hex_display.md
Name: dev_hex_display

Overview:
- Drives a two-digit multiplexed 7-segment display (PmodSSD style): 7 segment lines plus 1 digit-select line.
- Shows an 8-bit value as two hex digits.
- Used as the status/exit-code display of the ULM system: loader byte while loading, CPU exit code after halt.
- `en` gates visibility; the display blanks when `en` is low.

Parameters:
- CLK_FREQ, 12_000_000, input clock frequency in Hz.
- REFRESH_HZ, 1_000, digit-select toggle rate in Hz.
- Derived DIV = CLK_FREQ/REFRESH_HZ, integer division; required DIV >= 2 (elaboration error otherwise).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  display enable; 1 = show value, 0 = blank.
- hex_val  input  8  value to show; [7:4] high digit, [3:0] low digit.
- hex_pins  output  8  [6:0] segments g..a (bit0=a … bit6=g, active-high); [7] digit select (0 = low-nibble digit, 1 = high-nibble digit).

Behaviour:
- Refresh counter cnt, width clog2(DIV):
  - Increments every cycle.
  - At DIV-1 it wraps to 0 and toggles sel in the same cycle.
  - Hence sel period = 2*DIV cycles, each digit lit DIV cycles.
- Value register val_q: loads hex_val on every cycle with en=1; holds when en=0.
- Blank register blank_q <= !en.
- Output register, hex_pins updated every cycle:
  - hex_pins[7] <= sel.
  - hex_pins[6:0] <= blank_q ? 7'h00 : seg(sel ? val_q[7:4] : val_q[3:0]).
  - Digit select keeps toggling while blanked.
- Latency:
  - hex_val/en change to pins = 2 cycles (input reg, then output reg).
  - sel toggle to pins[7] = 1 cycle, with segments of the matching digit in the same cycle (no ghosting).
- Segment encoding (hex, bit6..0 = gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset (rst=1 at clock edge):
  - cnt=0, sel=0, val_q=8'h00, blank_q=1, hex_pins=8'h00.
  - Takes priority over en.
  - Reset mid-refresh restarts the counter: the first toggle comes DIV cycles after rst deasserts.
- Boundaries:
  - hex_val=8'h00 shows "00".
  - 8'hFF shows "FF".
  - en toggling every cycle: pins follow en delayed by 2 cycles, no glitch beyond register granularity.
  - hex_val changing mid-digit: the new value appears on the currently selected digit 2 cycles later; no waiting for a refresh boundary.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DEV_HEX_LEADING_ZERO_BLANK_EN.
- Defined:
  - When val_q[7:4]==0 and sel=1, segments output 7'h00 (high digit blanked).
  - The low digit is always shown, so 8'h00 displays " 0" and 8'h0A displays " A".
- Undefined: both digits always shown, including leading zero.
- Digit-select timing is identical in both builds.

Test Plan (CLK_FREQ=100, REFRESH_HZ=10 → DIV=10):
- Reset: rst=1 for 3 cycles, then rst=0 with en=0 → hex_pins=8'h00 during reset; pins[7] first rises 10 cycles after rst deasserts, then toggles every 10 cycles; pins[6:0] stay 00.
- Enable and display: en=1, hex_val=8'h3A → while pins[7]=0, pins[6:0]=7'h77; while pins[7]=1, pins[6:0]=7'h4F; first valid segments 2 cycles after en rises.
- Full encoding sweep: hex_val=8'h00,8'h11,…,8'hFF, each held 40 cycles → both digits match the 16-entry table for every nibble.
- Blanking: display 8'h5C, then en=0 for 25 cycles → pins[6:0]=00 from 2 cycles after the fall while pins[7] keeps toggling; on en=1 with hex_val unchanged, 8'h5C reappears (6D / 39) after 2 cycles.
- Reset mid-operation: pulse rst at cnt=6 with hex_val=8'hE7, en=1 → pins=8'h00 the cycle after; val_q reloads; next sel toggle exactly 10 cycles after rst deassert; shows 07 / 79.
- Option build with DEV_HEX_LEADING_ZERO_BLANK_EN: hex_val=8'h05 → high digit 00, low digit 6D; without the macro → high digit 3F.
